// File: rtl/tft_capture.sv
// TFT panel capture: brings the panel pixel-clock domain into clk, extracts
// pixels with coordinates and tracks frame geometry to report timing lock.
module tft_capture #(
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tft_clk,
  input  logic        tft_h,
  input  logic        tft_v,
  input  logic        de,
  input  logic [3:0]  tft_r,
  input  logic [3:0]  tft_g,
  input  logic [3:0]  tft_b,
  output logic [14:0] pixel,
  output logic        pixel_valid,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        frame_start,
  output logic [9:0]  line_len,
  output logic        locked,
  output logic        err
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  state_t      state, state_n;
  logic [15:0] sync1, sync2;
  logic        tclk_prev, v_prev, de_prev;
  logic [9:0]  pcnt, flen, ref_len, ln_flen;
  logic [8:0]  ref_cnt, ln_y;
  logic        fok, ln_ok, cons, match;
  logic [2:0]  good, good_n;
  logic        ref_load, err_n;
  logic        sample, vs_edge, de_fall, s_v, s_de;
  logic [3:0]  s_r, s_g, s_b;
  logic        h_unused;

  // All panel inputs share one pipeline so they stay aligned with tft_clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      tclk_prev <= 1'b0;
    end else begin
      sync1     <= {tft_clk, tft_h, tft_v, de, tft_r, tft_g, tft_b};
      sync2     <= sync1;
      tclk_prev <= sync2[15];
    end
  end

  assign h_unused = sync2[14];
  assign s_v      = sync2[13];
  assign s_de     = sync2[12];
  assign s_r      = sync2[11:8];
  assign s_g      = sync2[7:4];
  assign s_b      = sync2[3:0];
  assign sample   = sync2[15] & ~tclk_prev;
  assign vs_edge  = sample && (s_v == SYNC_ACTIVE) && (v_prev != SYNC_ACTIVE);
  assign de_fall  = sample && !s_de && de_prev;

  // Line-end effect on frame statistics, resolved before any frame-end decision.
  always_comb begin
    ln_y    = y;
    ln_flen = flen;
    ln_ok   = fok;
    if (de_fall) begin
      ln_y = (y == 9'd511) ? y : y + 9'd1;
      if (y == 9'd0) begin
        ln_flen = pcnt;
        ln_ok   = (pcnt != 10'd0);
      end else if (pcnt != flen) begin
        ln_ok = 1'b0;
      end
    end
  end

  assign cons  = ln_ok && (ln_y != 9'd0);
  assign match = (ln_flen == ref_len) && (ln_y == ref_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_prev      <= 1'b0;
      de_prev     <= 1'b0;
      pcnt        <= '0;
      flen        <= '0;
      fok         <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      if (sample) begin
        v_prev  <= s_v;
        de_prev <= s_de;
        if (s_de) begin
          pixel       <= {s_b, s_b[3], s_g, s_g[3], s_r, s_r[3]};
          x           <= (pcnt > 10'd511) ? 9'd511 : pcnt[8:0];
          pcnt        <= (pcnt == 10'd1023) ? pcnt : pcnt + 10'd1;
          pixel_valid <= 1'b1;
        end
        if (de_fall) begin
          line_len <= pcnt;
          pcnt     <= '0;
          x        <= '0;
        end
        y    <= ln_y;
        flen <= ln_flen;
        fok  <= ln_ok;
        if (vs_edge) begin
          y           <= '0;
          flen        <= '0;
          fok         <= 1'b1;
          frame_start <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      good    <= '0;
      ref_len <= '0;
      ref_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      good  <= good_n;
      err   <= err_n;
      if (ref_load) begin
        ref_len <= ln_flen;
        ref_cnt <= ln_y;
      end
    end
  end

  always_comb begin
    state_n  = state;
    good_n   = good;
    ref_load = 1'b0;
    err_n    = 1'b0;
    if (vs_edge) begin
      unique case (state)
        SEARCH: begin
          state_n = TRACK;
          good_n  = '0;
        end
        TRACK: begin
          if (cons && (good == 3'd0 || match)) begin
            good_n   = good + 3'd1;
            ref_load = 1'b1;
          end else if (cons) begin
            good_n   = 3'd1;
            ref_load = 1'b1;
          end else begin
            good_n = '0;
          end
          if (good_n == LOCK_N) state_n = LOCKED;
        end
        LOCKED: begin
          if (!(cons && match)) begin
            state_n = TRACK;
            good_n  = '0;
            err_n   = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tft_capture.sv
// Randomized scoreboard bench for tft_capture: pixel expectations are queued at
// stimulus time and popped by a monitor; frame-level lock model checked per vsync.
module tb_tft_capture;
  localparam bit          SA = 1'b0;
  localparam int unsigned LF = 2;

  logic        clk = 1'b0;
  logic        reset, tft_clk, tft_h, tft_v, de;
  logic [3:0]  tft_r, tft_g, tft_b;
  logic [14:0] pixel;
  logic        pixel_valid, frame_start, locked, err;
  logic [8:0]  x, y;
  logic [9:0]  line_len;

  tft_capture #(.SYNC_ACTIVE(SA), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .tft_clk(tft_clk), .tft_h(tft_h), .tft_v(tft_v),
    .de(de), .tft_r(tft_r), .tft_g(tft_g), .tft_b(tft_b), .pixel(pixel),
    .pixel_valid(pixel_valid), .x(x), .y(y), .frame_start(frame_start),
    .line_len(line_len), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] p;
    logic [8:0]  x;
    logic [8:0]  y;
  } ev_t;

  ev_t pq[$];
  ev_t mon_e;
  int  n_cmp = 0, n_bad = 0;
  int  fs_seen = 0, err_seen = 0, fs_exp = 0, err_exp = 0;
  int  col = 0, ycur = 0, exp_ll = 0;
  int  fr[$];
  bit  tracking = 0, lockd = 0;
  int  run = 0, last_len = 0, last_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) fs_seen++;
      if (err) err_seen++;
      if (pixel_valid) begin
        if (pq.size() == 0) begin
          check("pixel_unexpected_valid", {31'd0, pixel_valid}, 32'd0);
        end else begin
          mon_e = pq.pop_front();
          check("pixel", {17'd0, pixel}, {17'd0, mon_e.p});
          check("x", {23'd0, x}, {23'd0, mon_e.x});
          check("y", {23'd0, y}, {23'd0, mon_e.y});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input bit vact, input bit d, input logic [3:0] r, g, b);
    tft_v = vact ? SA : ~SA;
    de = d; tft_r = r; tft_g = g; tft_b = b;
    tft_clk = 1'b0;
    #20;
    tft_clk = 1'b1;
    #20;
  endtask

  task automatic pix(input logic [3:0] r, g, b);
    ev_t e;
    e.p = {b, b[3], g, g[3], r, r[3]};
    e.x = 9'((col > 511) ? 511 : col);
    e.y = 9'(ycur);
    pq.push_back(e);
    col++;
    tick(1'b0, 1'b1, r, g, b);
  endtask

  task automatic record_line();
    exp_ll = (col > 1023) ? 1023 : col;
    fr.push_back(exp_ll);
    ycur = (ycur == 511) ? 511 : ycur + 1;
    col = 0;
  endtask

  task automatic send_line(input int len, input bit into_vs);
    for (int i = 0; i < len; i++) pix(4'($urandom), 4'($urandom), 4'($urandom));
    if (!into_vs) begin
      tick(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      record_line();
      repeat (3) tick(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      check("line_len", {22'd0, line_len}, 32'(exp_ll));
    end
  endtask

  // A frame is summarized by (line length, line count); lock needs LF
  // consecutive identical consistent frames and holds while frames keep matching.
  task automatic vsync(input bit line_end);
    int cnt;
    bit cons;
    if (line_end) record_line();
    cnt  = (fr.size() > 511) ? 511 : fr.size();
    cons = (fr.size() > 0);
    foreach (fr[i]) if (fr[i] != fr[0]) cons = 0;
    if (!tracking) begin
      tracking = 1; run = 0;
    end else if (lockd) begin
      if (!(cons && fr[0] == last_len && cnt == last_cnt)) begin
        lockd = 0; run = 0; err_exp++;
      end
    end else begin
      if (cons && run > 0 && fr[0] == last_len && cnt == last_cnt) run++;
      else if (cons) run = 1;
      else run = 0;
      if (cons) begin last_len = fr[0]; last_cnt = cnt; end
      if (run >= LF) lockd = 1;
    end
    fr.delete();
    ycur = 0;
    fs_exp++;
    repeat (2) tick(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (2) tick(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    check("locked", {31'd0, locked}, {31'd0, lockd});
    check("err_pulses", 32'(err_seen), 32'(err_exp));
    check("frame_start_pulses", 32'(fs_seen), 32'(fs_exp));
    if (line_end) check("line_len_at_vsync", {22'd0, line_len}, 32'(exp_ll));
  endtask

  task automatic send_frame(input int n, input int len, input bit bad, input bit coinc);
    for (int l = 0; l < n; l++)
      send_line((bad && l == n - 1) ? len - 1 : len, coinc && l == n - 1);
    vsync(coinc && n > 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, {17'd0, pixel}, 32'd0);
    check({tag, "_pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
    check({tag, "_x"}, {23'd0, x}, 32'd0);
    check({tag, "_y"}, {23'd0, y}, 32'd0);
    check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    check({tag, "_line_len"}, {22'd0, line_len}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int la, na, lb, nb, m;
    bit co;
    reset = 1'b1; tft_clk = 1'b0; tft_v = ~SA; tft_h = ~SA; de = 1'b0;
    tft_r = 4'h0; tft_g = 4'h0; tft_b = 4'h0;
    #23;
    check_all_zero("reset");
    reset = 1'b0;
    #20;

    // Single known pixel, then a blank: expanded colour and x=0.
    pix(4'hF, 4'h0, 4'h8);
    #40;
    check("known_pixel", {17'd0, pixel}, 32'h441F);
    tick(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    record_line();
    repeat (3) tick(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    check("line_len_one", {22'd0, line_len}, 32'd1);

    // Lock acquisition with 256-pixel lines.
    vsync(1'b0);
    send_frame(3, 256, 1'b0, 1'b0);
    send_frame(3, 256, 1'b0, 1'b0);
    check("locked_after_third_vsync", {31'd0, locked}, 32'd1);
    check("line_len_256", {22'd0, line_len}, 32'd256);

    // One 255-pixel line breaks lock; two good frames regain it.
    send_frame(3, 256, 1'b1, 1'b0);
    check("err_once", 32'(err_seen), 32'd1);
    send_frame(3, 256, 1'b0, 1'b0);
    send_frame(3, 256, 1'b0, 1'b0);
    check("relocked", {31'd0, locked}, 32'd1);

    // Reset mid-line while locked.
    for (int i = 0; i < 5; i++) pix(4'($urandom), 4'($urandom), 4'($urandom));
    de = 1'b0; tft_clk = 1'b0;
    #60;
    check("queue_drained_before_reset", 32'(pq.size()), 32'd0);
    #3 reset = 1'b1;
    #1;
    check_all_zero("midline_reset");
    #27 reset = 1'b0;
    col = 0; ycur = 0; fr.delete(); tracking = 0; lockd = 0; run = 0; exp_ll = 0;
    #20;

    send_line(7, 1'b0);
    vsync(1'b0);

    // Randomized frames: two geometries, broken frames, empty frames, line end on vsync.
    la = $urandom_range(2, 24); na = $urandom_range(1, 4);
    lb = $urandom_range(2, 24); nb = $urandom_range(1, 4);
    for (int k = 0; k < 14; k++) begin
      m  = $urandom_range(0, 5);
      co = 1'($urandom_range(0, 1));
      case (m)
        0, 1, 2: send_frame(na, la, 1'b0, co);
        3:       send_frame(nb, lb, 1'b0, co);
        4:       send_frame(na + 1, la, 1'b1, co);
        default: send_frame(0, la, 1'b0, 1'b0);
      endcase
    end

    // Long lines: x saturates at 511, pixel count at 1023.
    send_frame(1, 600, 1'b0, 1'b0);
    send_frame(1, 1100, 1'b0, 1'b0);
    check("line_len_saturated", {22'd0, line_len}, 32'd1023);

    // de falling on the same sample as the vsync edge.
    send_frame(3, 12, 1'b0, 1'b1);
    send_frame(3, 12, 1'b0, 1'b1);
    send_frame(3, 12, 1'b0, 1'b1);
    check("y_cleared_after_coincident", {23'd0, y}, 32'd0);
    check("line_len_coincident", {22'd0, line_len}, 32'd12);

    #200;
    check("pixel_queue_empty", 32'(pq.size()), 32'd0);
    check("final_frame_start", 32'(fs_seen), 32'(fs_exp));
    check("final_err", 32'(err_seen), 32'(err_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
